// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite word-addressed memory slave: independent AW/W latching, one write outstanding, 1-cycle reads.
// Optional macro AXI_SLV_RANGE_CHECK_EN: addresses beyond the memory depth answer SLVERR.
module axi_lite_mem_slave #(
    parameter int unsigned AWIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_awaddr,
    input  logic [2:0]  axi_awprot,

    input  logic        axi_wvalid,
    output logic        axi_wready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,

    output logic        axi_bvalid,
    input  logic        axi_bready,
    output logic [1:0]  axi_bresp,

    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [31:0] axi_araddr,
    input  logic [2:0]  axi_arprot,

    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp
);

    localparam int unsigned DEPTH       = 2 ** AWIDTH;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic [31:0]       mem [DEPTH];

    logic              aw_held;
    logic              w_held;
    logic [31:0]       aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic [1:0]        rresp_q;

    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              commit;
    logic [31:0]       wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic [AWIDTH-1:0] wr_idx;
    logic [AWIDTH-1:0] rd_idx;
    logic              wr_oor;
    logic              rd_oor;

    // Ready terms follow slot occupancy; nothing is accepted while reset is held.
    assign axi_awready = ~rst & ~aw_held & ~bvalid_q;
    assign axi_wready  = ~rst & ~w_held & ~bvalid_q;
    assign axi_arready = ~rst & (~rvalid_q | axi_rready);

    assign aw_hs  = axi_awvalid & axi_awready;
    assign w_hs   = axi_wvalid & axi_wready;
    assign ar_hs  = axi_arvalid & axi_arready;
    assign commit = ~rst & (aw_held | aw_hs) & (w_held | w_hs);

    // A held slot takes priority; otherwise the beat handshaking this edge is used.
    assign wr_addr = aw_held ? aw_addr_q : axi_awaddr;
    assign wr_data = w_held ? w_data_q : axi_wdata;
    assign wr_strb = w_held ? w_strb_q : axi_wstrb;
    assign wr_idx  = wr_addr[AWIDTH+1:2];
    assign rd_idx  = axi_araddr[AWIDTH+1:2];

`ifdef AXI_SLV_RANGE_CHECK_EN
    assign wr_oor = (wr_addr >> (AWIDTH + 2)) != 32'd0;
    assign rd_oor = (axi_araddr >> (AWIDTH + 2)) != 32'd0;
`else
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{axi_awprot, axi_arprot, wr_addr, axi_araddr};

    // Byte-enabled storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (commit && !wr_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Write slots and response channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= 32'd0;
            w_data_q  <= 32'd0;
            w_strb_q  <= 4'd0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_addr_q <= axi_awaddr;
            end
            if (w_hs) begin
                w_data_q <= axi_wdata;
                w_strb_q <= axi_wstrb;
            end
            aw_held <= (aw_held | aw_hs) & ~commit;
            w_held  <= (w_held | w_hs) & ~commit;
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_oor ? RESP_SLVERR : RESP_OKAY;
            end else if (axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read channel; the memory read here sees the pre-write word on a colliding edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_oor ? 32'd0 : mem[rd_idx];
            rresp_q  <= rd_oor ? RESP_SLVERR : RESP_OKAY;
        end else if (axi_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign axi_bvalid = bvalid_q;
    assign axi_bresp  = bresp_q;
    assign axi_rvalid = rvalid_q;
    assign axi_rdata  = rdata_q;
    assign axi_rresp  = rresp_q;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed self-checking bench for axi_lite_mem_slave (AWIDTH=8); honours AXI_SLV_RANGE_CHECK_EN.
module tb_axi_lite_mem_slave;

    logic        clk;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;

    axi_lite_mem_slave #(.AWIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr), .axi_awprot(awprot),
        .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb),
        .axi_bvalid(bvalid), .axi_bready(bready), .axi_bresp(bresp),
        .axi_arvalid(arvalid), .axi_arready(arready), .axi_araddr(araddr), .axi_arprot(arprot),
        .axi_rvalid(rvalid), .axi_rready(rready), .axi_rdata(rdata), .axi_rresp(rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Same-cycle AW+W write with bready=1; returns bresp.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        int n;
        @(negedge clk);
        awvalid = 1'b1; awaddr = addr; wvalid = 1'b1; wdata = data; wstrb = strb; bready = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL write_timeout addr=%h bvalid=%b expected 1", addr, bvalid);
        end
        resp = bresp;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(negedge clk);
        arvalid = 1'b1; araddr = addr; rready = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (rvalid !== 1'b1) begin
            errors++;
            $display("FAIL read_timeout addr=%h rvalid=%b expected 1", addr, rvalid);
        end
        data = rdata;
        resp = rresp;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b expected 00000", {awready, wready, arready, bvalid, rvalid});
        end
        checks++;
        if ({bresp, rresp, rdata} !== 36'd0) begin
            errors++;
            $display("FAIL reset_data bresp=%b rresp=%b rdata=%h expected 0", bresp, rresp, rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release got=%b expected 111", {awready, wready, arready});
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic [1:0]  r;
        @(negedge clk);
        awvalid = 1'b1; awaddr = 32'h10; wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; bready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL basic_b bvalid=%b bresp=%b expected 1/00", bvalid, bresp);
        end
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL basic_b_done bvalid=%b expected 0", bvalid);
        end
        arvalid = 1'b1; araddr = 32'h10; rready = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || rresp !== 2'b00) begin
            errors++;
            $display("FAIL basic_r rvalid=%b rdata=%h rresp=%b expected 1/deadbeef/00", rvalid, rdata, rresp);
        end
        @(negedge clk);
        do_read(32'h10, d, r);
        checks++;
        if (d !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_reread got=%h expected deadbeef", d);
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d;
        logic [1:0]  r;
        @(negedge clk);
        wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'hF; bready = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
                errors++;
                $display("FAIL w_held cyc=%0d wready=%b awready=%b bvalid=%b expected 0/1/0",
                         i, wready, awready, bvalid);
            end
            if (i < 2) @(negedge clk);
        end
        awvalid = 1'b1; awaddr = 32'h20;
        @(negedge clk);
        awvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL w_first_b bvalid=%b expected 1", bvalid);
        end
        @(negedge clk);
        do_read(32'h20, d, r);
        checks++;
        if (d !== 32'h11223344) begin
            errors++;
            $display("FAIL w_first_data got=%h expected 11223344", d);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(32'h30, 32'h00000000, 4'hF, r);
        do_write(32'h30, 32'hAABBCCDD, 4'b0101, r);
        do_read(32'h30, d, r);
        checks++;
        if (d !== 32'h00BB00DD) begin
            errors++;
            $display("FAIL strobe got=%h expected 00bb00dd", d);
        end
    endtask

    task automatic test_b_stall();
        logic [31:0] d;
        logic [1:0]  r;
        @(negedge clk);
        awvalid = 1'b1; awaddr = 32'h40; wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; bready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin awaddr = 32'h44; wvalid = 1'b0; wdata = 32'h66; end
            checks++;
            if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
                errors++;
                $display("FAIL b_stall cyc=%0d bvalid=%b awready=%b wready=%b expected 1/0/0",
                         i, bvalid, awready, wready);
            end
        end
        bready = 1'b1;
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            errors++;
            $display("FAIL b_release bvalid=%b awready=%b expected 0/1", bvalid, awready);
        end
        @(negedge clk);
        awvalid = 1'b0;
        checks++;
        if (awready !== 1'b0 || wready !== 1'b1 || bvalid !== 1'b0) begin
            errors++;
            $display("FAIL aw_second_held awready=%b wready=%b bvalid=%b expected 0/1/0",
                     awready, wready, bvalid);
        end
        wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL second_b bvalid=%b expected 1", bvalid);
        end
        @(negedge clk);
        do_read(32'h40, d, r);
        checks++;
        if (d !== 32'h55) begin
            errors++;
            $display("FAIL b_stall_w1 got=%h expected 00000055", d);
        end
        do_read(32'h44, d, r);
        checks++;
        if (d !== 32'h66) begin
            errors++;
            $display("FAIL b_stall_w2 got=%h expected 00000066", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [1:0]  r;
        @(negedge clk);
        bready = 1'b1; wstrb = 4'hF;
        for (int k = 0; k < 3; k++) begin
            awvalid = 1'b1; wvalid = 1'b1;
            awaddr = 32'h50 + 32'(4 * k); wdata = 32'h1000 + 32'(k);
            checks++;
            if (awready !== 1'b1 || wready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready k=%0d awready=%b wready=%b expected 1/1", k, awready, wready);
            end
            @(negedge clk);
            checks++;
            if (bvalid !== 1'b1 || awready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_resp k=%0d bvalid=%b awready=%b expected 1/0", k, bvalid, awready);
            end
            @(negedge clk);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            do_read(32'h50 + 32'(4 * k), d, r);
            checks++;
            if (d !== 32'h1000 + 32'(k)) begin
                errors++;
                $display("FAIL b2b_data k=%0d got=%h expected %h", k, d, 32'h1000 + 32'(k));
            end
        end
    endtask

    task automatic test_read_stall_reset();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(32'h60, 32'hCAFEF00D, 4'hF, r);
        @(negedge clk);
        arvalid = 1'b1; araddr = 32'h60; rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) arvalid = 1'b0;
            if (i == 1) begin awvalid = 1'b1; awaddr = 32'h60; end
            if (i == 2) awvalid = 1'b0;
            checks++;
            if (rvalid !== 1'b1 || rdata !== 32'hCAFEF00D || arready !== 1'b0) begin
                errors++;
                $display("FAIL r_stall cyc=%0d rvalid=%b rdata=%h arready=%b expected 1/cafef00d/0",
                         i, rvalid, rdata, arready);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL r_reset rvalid=%b expected 0", rvalid);
        end
        rst = 1'b0; rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rvalid !== 1'b0 || bvalid !== 1'b0 || awready !== 1'b1) begin
                errors++;
                $display("FAIL post_reset cyc=%0d rvalid=%b bvalid=%b awready=%b expected 0/0/1",
                         i, rvalid, bvalid, awready);
            end
        end
        do_read(32'h60, d, r);
        checks++;
        if (d !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL reset_mem got=%h expected cafef00d", d);
        end
    endtask

    task automatic test_same_edge();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(32'h70, 32'h11111111, 4'hF, r);
        @(negedge clk);
        awvalid = 1'b1; awaddr = 32'h70; wvalid = 1'b1; wdata = 32'h22222222; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 32'h70; rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h11111111 || bvalid !== 1'b1) begin
            errors++;
            $display("FAIL rbw rvalid=%b rdata=%h bvalid=%b expected 1/11111111/1", rvalid, rdata, bvalid);
        end
        @(negedge clk);
        do_read(32'h70, d, r);
        checks++;
        if (d !== 32'h22222222) begin
            errors++;
            $display("FAIL rbw_after got=%h expected 22222222", d);
        end
    endtask

    task automatic test_range();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(32'h000, 32'h0BADF00D, 4'hF, r);
        do_write(32'h400, 32'h12345678, 4'hF, r);
`ifdef AXI_SLV_RANGE_CHECK_EN
        checks++;
        if (r !== 2'b10) begin
            errors++;
            $display("FAIL range_bresp got=%b expected 10", r);
        end
        do_read(32'h000, d, r);
        checks++;
        if (d !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL range_mem got=%h expected 0badf00d", d);
        end
        do_read(32'h400, d, r);
        checks++;
        if (d !== 32'd0 || r !== 2'b10) begin
            errors++;
            $display("FAIL range_read rdata=%h rresp=%b expected 00000000/10", d, r);
        end
`else
        checks++;
        if (r !== 2'b00) begin
            errors++;
            $display("FAIL alias_bresp got=%b expected 00", r);
        end
        do_read(32'h000, d, r);
        checks++;
        if (d !== 32'h12345678 || r !== 2'b00) begin
            errors++;
            $display("FAIL alias_mem rdata=%h rresp=%b expected 12345678/00", d, r);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        awvalid = 1'b0; awaddr = 32'd0; awprot = 3'd0;
        wvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; bready = 1'b0;
        arvalid = 1'b0; araddr = 32'd0; arprot = 3'd0; rready = 1'b0;
        test_reset();
        test_basic();
        test_w_before_aw();
        test_strobe();
        test_b_stall();
        test_back_to_back();
        test_read_stall_reset();
        test_same_edge();
        test_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
